b9_event_fifo: RTL and testbench
================================

# b9_event_fifo

Change-event logger placed directly downstream of the b9 control decode block. It samples that block's 21-bit output vector (p0..j1) whenever the vector is marked valid. It records each sample that differs from the previous one, together with a free-running timestamp, into a small FIFO. A consumer drains the FIFO over a valid/ready handshake. Overflow is reported, never silently lost.

## Interface
Parameters:
- VEC_W, 21, width of monitored vector (bit order p0..j1, p0 = bit 0)
- DEPTH, 8, FIFO entries (power of two, ≥2)
- TS_W, 16, timestamp width
- DROP_W, 8, dropped-event counter width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  in_vec is meaningful this cycle
- in_vec  in  VEC_W  output vector of the upstream decode block
- out_valid  out  1  FIFO head entry present
- out_ready  in  1  consumer accepts head this cycle
- out_vec  out  VEC_W  head entry vector
- out_ts  out  TS_W  head entry timestamp
- count  out  $clog2(DEPTH)+1  occupancy
- overflow  out  1  sticky; an event was dropped
- drop_cnt  out  DROP_W  dropped events, saturating
- clr_ovf  in  1  clears overflow and drop_cnt

## Operation
- ts: free-running counter, +1 every cycle, wraps 2^TS_W-1 → 0.
- primed: cleared by reset, set on first in_valid.
- last_vec: loaded with in_vec on every in_valid cycle, including dropped ones.
- event = in_valid && (!primed || in_vec != last_vec).
- An event captures {in_vec, ts}, where ts is the counter value in the event cycle.
- Push accepted if count < DEPTH, or if a pop occurs in the same cycle.
- Otherwise the event is dropped:
  - overflow ← 1
  - drop_cnt ← drop_cnt+1, saturating at 2^DROP_W-1
- Pop = out_valid && out_ready.
- FIFO is show-ahead: out_vec/out_ts hold the head entry whenever out_valid=1.
- When out_valid=0, out_vec/out_ts hold their last value (0 after reset).
- clr_ovf: overflow and drop_cnt ← 0 next cycle.
  - If a drop occurs in the same cycle, the drop wins: overflow=1, drop_cnt=1.
- Simultaneous push and pop:
  - when empty, the new entry becomes head next cycle;
  - when full, count is unchanged and the head advances.
- Pointers wrap modulo DEPTH.
- No state machine beyond primed; control is the FIFO counters.

## Timing
- Reset values: out_valid 0, out_vec 0, out_ts 0, count 0, overflow 0, drop_cnt 0, ts 0, primed 0, last_vec 0, pointers 0.
- Reset asserted mid-operation discards all contents immediately (asynchronous).
- Push-to-out_valid latency: 1 cycle (event at edge N → out_valid high after edge N+1).
- count updates on the same edge as push/pop.
- out_valid drops on the edge that pops the last entry, unless a push occurs on that same edge.
- All outputs are registered; no combinational path from in_* to out_*.
- out_ready → out_valid has no combinational path. out_ready only affects state at the edge.

## Structure
- Package b9_mon_pkg holds:
  - VEC_W = 21
  - localparam bit indices for p0..j1
  - typedef struct packed {logic [TS_W-1:0] ts; logic [VEC_W-1:0] vec;} b9_evt_t
- Sub-module b9_mon_fifo: a generic show-ahead synchronous FIFO. It has push/pop, data in/out, count, full and empty, with a register-array memory.
- The top level holds ts, primed, last_vec, event detection and overflow/drop logic.

## Test plan
- Reset, then in_valid=1 with in_vec=0x000001 at ts=5, out_ready=0 → out_valid=1 one cycle later; out_vec=0x000001, out_ts=5, count=1.
- Repeat the same vector for 10 cycles → count stays 1, no new entries. Then change to 0x100000 → second entry logged with the correct ts.
- 12 distinct vectors on consecutive cycles, out_ready=0, DEPTH=8:
  - count=8
  - overflow=1, drop_cnt=4
  - drained entries hold vectors 1..8 in order.
- FIFO full, with an event and out_ready=1 in the same cycle → no drop, count stays 8, head advances.
- clr_ovf pulsed while a drop occurs in the same cycle → overflow=1, drop_cnt=1. Next cycle, clr_ovf alone → both 0.
- Timestamp wrap at TS_W=4: an event at ts=15 and the next at ts=0 → out_ts values 15, then 0.
- rst_n pulsed low asynchronously with 3 entries queued → out_valid, count and overflow are 0 before the next clock edge.
- After that reset, the first in_valid is logged even if it equals the old vector.

Source files
------------

// File: rtl/b9_mon_pkg.sv
// Shared definitions for the b9 change-event monitor: vector width,
// bit positions of the monitored decode outputs and the event record.
package b9_mon_pkg;

    // Width of the monitored decode vector and of the default timestamp.
    localparam int VEC_W = 21;
    localparam int TS_W  = 16;

    // Bit positions of the decode outputs inside the vector. Bit order runs
    // p0 (bit 0) up to j1 (bit 20) in the decode block's output order.
    localparam int P0_BIT = 0;
    localparam int J1_BIT = VEC_W - 1;

    // One logged event: the vector plus the timestamp of the cycle it changed.
    typedef struct packed {
        logic [TS_W-1:0]  ts;
        logic [VEC_W-1:0] vec;
    } b9_evt_t;

endpackage : b9_mon_pkg

// File: rtl/b9_mon_fifo.sv
// Generic show-ahead synchronous FIFO with a register-array memory.
// The head entry is held in an output register so that dout/valid are
// flop outputs; dout keeps its last value once the FIFO runs empty.
module b9_mon_fifo
    import b9_mon_pkg::*;
#(
    parameter int DATA_W = $bits(b9_evt_t),
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     srst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        din,
    input  logic                     pop,
    output logic [DATA_W-1:0]        dout,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int                 PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0]     DEPTH_C = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]     ONE_C   = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]     ZERO_C  = {(PTR_W + 1){1'b0}};
    localparam logic [PTR_W-1:0]   PTR_ONE = PTR_W'(1);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W:0]    count_r;
    logic [DATA_W-1:0] head_r;
    logic              valid_r;

    logic              wr_en_s;
    logic              rd_en_s;
    logic              full_s;
    logic [PTR_W-1:0]  rd_nxt_s;
    logic [PTR_W:0]    count_nxt_s;
    logic [DATA_W-1:0] head_nxt_s;

    assign full_s   = (count_r == DEPTH_C);
    assign rd_en_s  = pop && valid_r;
    // A write into a full FIFO is only legal when the head leaves on the same edge.
    assign wr_en_s  = push && (!full_s || rd_en_s);
    assign rd_nxt_s = rd_ptr_r + PTR_ONE;

    // Next occupancy and next head entry from this cycle's push/pop.
    always_comb begin
        count_nxt_s = count_r;
        head_nxt_s  = head_r;
        if (wr_en_s && !rd_en_s) begin
            count_nxt_s = count_r + ONE_C;
        end else if (!wr_en_s && rd_en_s) begin
            count_nxt_s = count_r - ONE_C;
        end else begin
            count_nxt_s = count_r;
        end

        if (rd_en_s) begin
            if (count_r > ONE_C) begin
                // Next-oldest stored entry becomes head; when full the write
                // lands in the slot just vacated, never in this one.
                head_nxt_s = mem_r[rd_nxt_s];
            end else if (wr_en_s) begin
                head_nxt_s = din;
            end else begin
                head_nxt_s = head_r;
            end
        end else if (wr_en_s && (count_r == ZERO_C)) begin
            head_nxt_s = din;
        end else begin
            head_nxt_s = head_r;
        end
    end

    // Storage array; contents need no reset because pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers, occupancy and registered head/valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= ZERO_C;
            head_r   <= {DATA_W{1'b0}};
            valid_r  <= 1'b0;
        end else if (srst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= ZERO_C;
            head_r   <= {DATA_W{1'b0}};
            valid_r  <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_nxt_s;
            end
            count_r <= count_nxt_s;
            head_r  <= head_nxt_s;
            valid_r <= (count_nxt_s != ZERO_C);
        end
    end

    assign dout  = head_r;
    assign valid = valid_r;
    assign count = count_r;
    assign full  = full_s;
    assign empty = !valid_r;

endmodule : b9_mon_fifo

// File: rtl/b9_event_fifo.sv
// Change-event logger for the b9 decode output vector. Every valid sample
// that differs from the previous one (or the first after reset) is queued
// with a free-running timestamp; events that find the queue full are
// counted and flagged instead of being lost silently.
module b9_event_fifo #(
    parameter int VEC_W  = b9_mon_pkg::VEC_W,
    parameter int DEPTH  = 8,
    parameter int TS_W   = b9_mon_pkg::TS_W,
    parameter int DROP_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [VEC_W-1:0]       in_vec,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [VEC_W-1:0]       out_vec,
    output logic [TS_W-1:0]        out_ts,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_cnt,
    input  logic                   clr_ovf
);

    localparam int                EVT_W    = VEC_W + TS_W;
    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};
    localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);

    logic [TS_W-1:0]   ts_r;
    logic              primed_r;
    logic [VEC_W-1:0]  last_vec_r;
    logic              overflow_r;
    logic [DROP_W-1:0] drop_cnt_r;

    logic              evt_s;
    logic              pop_s;
    logic              push_s;
    logic              drop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              fifo_valid_s;
    logic [EVT_W-1:0]  fifo_din_s;
    logic [EVT_W-1:0]  fifo_dout_s;
    logic              overflow_nxt_s;
    logic [DROP_W-1:0] drop_cnt_nxt_s;

    // Change detection: the first valid sample always counts as a change.
    always_comb begin
        evt_s = 1'b0;
        if (in_valid) begin
            if (!primed_r) begin
                evt_s = 1'b1;
            end else if (in_vec != last_vec_r) begin
                evt_s = 1'b1;
            end else begin
                evt_s = 1'b0;
            end
        end else begin
            evt_s = 1'b0;
        end
    end

    assign pop_s      = !fifo_empty_s && out_ready;
    assign push_s     = evt_s && (!fifo_full_s || pop_s);
    assign drop_s     = evt_s && !push_s;
    assign fifo_din_s = {ts_r, in_vec};

    // Overflow flag and saturating drop counter; a drop outranks a clear.
    always_comb begin
        overflow_nxt_s = overflow_r;
        drop_cnt_nxt_s = drop_cnt_r;
        if (drop_s) begin
            overflow_nxt_s = 1'b1;
            if (clr_ovf) begin
                drop_cnt_nxt_s = DROP_ONE;
            end else if (drop_cnt_r != DROP_MAX) begin
                drop_cnt_nxt_s = drop_cnt_r + DROP_ONE;
            end else begin
                drop_cnt_nxt_s = drop_cnt_r;
            end
        end else if (clr_ovf) begin
            overflow_nxt_s = 1'b0;
            drop_cnt_nxt_s = {DROP_W{1'b0}};
        end else begin
            overflow_nxt_s = overflow_r;
            drop_cnt_nxt_s = drop_cnt_r;
        end
    end

    // Timestamp, priming and last-sample tracking (last_vec follows every
    // valid sample, including ones whose event gets dropped).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_r       <= {TS_W{1'b0}};
            primed_r   <= 1'b0;
            last_vec_r <= {VEC_W{1'b0}};
        end else begin
            ts_r <= ts_r + TS_W'(1);
            if (in_valid) begin
                primed_r   <= 1'b1;
                last_vec_r <= in_vec;
            end
        end
    end

    // Overflow/drop status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= {DROP_W{1'b0}};
        end else begin
            overflow_r <= overflow_nxt_s;
            drop_cnt_r <= drop_cnt_nxt_s;
        end
    end

    b9_mon_fifo #(
        .DATA_W (EVT_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .srst  (1'b0),
        .push  (push_s),
        .din   (fifo_din_s),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .valid (fifo_valid_s),
        .count (count),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign out_valid = fifo_valid_s;
    assign out_vec   = fifo_dout_s[VEC_W-1:0];
    assign out_ts    = fifo_dout_s[EVT_W-1:VEC_W];
    assign overflow  = overflow_r;
    assign drop_cnt  = drop_cnt_r;

endmodule : b9_event_fifo

// File: tb/tb_b9_event_fifo.sv
// Scoreboard bench for b9_event_fifo: the driver queues each expected
// logged event, a negedge monitor compares every popped head entry.
// A second instance with a 4-bit timestamp covers timestamp wrap.
module tb_b9_event_fifo;

    localparam int VEC_W = 21;
    localparam int TS_W  = 16;
    localparam int DEPTH = 8;
    localparam int DROP_W = 8;
    localparam int CNT_W = 4;
    localparam int WTS_W = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic [VEC_W-1:0]   in_vec;
    logic               out_valid;
    logic               out_ready;
    logic [VEC_W-1:0]   out_vec;
    logic [TS_W-1:0]    out_ts;
    logic [CNT_W-1:0]   count;
    logic               overflow;
    logic [DROP_W-1:0]  drop_cnt;
    logic               clr_ovf;

    logic               w_in_valid;
    logic [VEC_W-1:0]   w_in_vec;
    logic               w_out_valid;
    logic               w_out_ready;
    logic [VEC_W-1:0]   w_out_vec;
    logic [WTS_W-1:0]   w_out_ts;
    logic [CNT_W-1:0]   w_count;
    logic               w_overflow;
    logic [DROP_W-1:0]  w_drop_cnt;
    logic               w_clr_ovf;

    typedef struct {
        logic [VEC_W-1:0] vec;
        logic [TS_W-1:0]  ts;
    } exp_t;

    exp_t sb_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   tb_ts;

    always #5 clk = ~clk;

    b9_event_fifo #(.VEC_W(VEC_W), .DEPTH(DEPTH), .TS_W(TS_W), .DROP_W(DROP_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_vec(in_vec),
        .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec), .out_ts(out_ts),
        .count(count), .overflow(overflow), .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
    );

    b9_event_fifo #(.VEC_W(VEC_W), .DEPTH(DEPTH), .TS_W(WTS_W), .DROP_W(DROP_W)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_vec(w_in_vec),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_vec(w_out_vec), .out_ts(w_out_ts),
        .count(w_count), .overflow(w_overflow), .drop_cnt(w_drop_cnt), .clr_ovf(w_clr_ovf)
    );

    // Reference cycle counter: equals the DUT timestamp between edges.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_ts <= 0;
        else        tb_ts <= tb_ts + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every head entry the consumer accepts must match the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                total_cnt++;
                $display("FAIL pop_unexpected: got vec 0x%0h ts %0d, expected no entry", out_vec, out_ts);
            end else begin
                e = sb_q.pop_front();
                check("pop_vec", 32'(out_vec), 32'(e.vec));
                check("pop_ts",  32'(out_ts),  32'(e.ts));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one valid sample; queue it as expected when it should be logged.
    task automatic send(input logic [VEC_W-1:0] v, input bit logged);
        exp_t e;
        in_valid = 1'b1;
        in_vec   = v;
        if (logged) begin
            e.vec = v;
            e.ts  = 16'(tb_ts);
            sb_q.push_back(e);
        end
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_vec = '0; out_ready = 1'b0; clr_ovf = 1'b0;
        w_in_valid = 1'b0; w_in_vec = '0; w_out_ready = 1'b0; w_clr_ovf = 1'b0;
        #22;
        rst_n = 1'b1;

        // Reset state
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_count",     32'(count),     32'd0);
        check("rst_overflow",  32'(overflow),  32'd0);
        check("rst_drop_cnt",  32'(drop_cnt),  32'd0);
        check("rst_out_vec",   32'(out_vec),   32'd0);
        check("rst_out_ts",    32'(out_ts),    32'd0);
        check("rst_w_count",   32'(w_count),   32'd0);
        tick();

        // First event at ts=5
        for (int i = 0; i < 20 && tb_ts < 5; i++) tick();
        send(21'h000001, 1'b1);
        check("first_out_valid", 32'(out_valid), 32'd1);
        check("first_out_vec",   32'(out_vec),   32'h000001);
        check("first_out_ts",    32'(out_ts),    32'd5);
        check("first_count",     32'(count),     32'd1);

        // Repeated vector is not logged; a change is
        for (int i = 0; i < 10; i++) send(21'h000001, 1'b0);
        check("repeat_count", 32'(count), 32'd1);
        send(21'h100000, 1'b1);
        in_valid = 1'b0;
        check("change_count", 32'(count), 32'd2);
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        check("drain_count",     32'(count),     32'd0);
        check("drain_out_valid", 32'(out_valid), 32'd0);
        check("drain_hold_vec",  32'(out_vec),   32'h100000);

        // Overflow: 12 distinct vectors into 8 entries
        for (int i = 1; i <= 12; i++) send(21'(i), (i <= 8));
        in_valid = 1'b0;
        check("ovf_count",    32'(count),    32'd8);
        check("ovf_flag",     32'(overflow), 32'd1);
        check("ovf_drop_cnt", 32'(drop_cnt), 32'd4);

        // Full with simultaneous pop: push accepted, head advances
        out_ready = 1'b1;
        send(21'd13, 1'b1);
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("fullpop_count",    32'(count),    32'd8);
        check("fullpop_drop_cnt", 32'(drop_cnt), 32'd4);
        check("fullpop_head",     32'(out_vec),  32'd2);

        // Clear together with a drop: drop wins
        clr_ovf = 1'b1;
        send(21'd14, 1'b0);
        in_valid = 1'b0;
        check("clrdrop_flag", 32'(overflow), 32'd1);
        check("clrdrop_cnt",  32'(drop_cnt), 32'd1);
        tick();
        clr_ovf = 1'b0;
        check("clr_flag", 32'(overflow), 32'd0);
        check("clr_cnt",  32'(drop_cnt), 32'd0);

        out_ready = 1'b1;
        repeat (8) tick();
        out_ready = 1'b0;
        check("drain2_count", 32'(count), 32'd0);
        check("drain2_sb",    32'(sb_q.size()), 32'd0);

        // Asynchronous reset with 3 entries queued
        send(21'h0AAAAA, 1'b1);
        send(21'h155555, 1'b1);
        send(21'h0AAAAA, 1'b1);
        in_valid = 1'b0;
        check("pre_arst_count", 32'(count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_count",     32'(count),     32'd0);
        check("arst_overflow",  32'(overflow),  32'd0);
        sb_q.delete();
        #2;
        rst_n = 1'b1;
        tick();

        // First sample after reset is logged even if equal to the old vector
        send(21'h0AAAAA, 1'b1);
        in_valid = 1'b0;
        check("reprime_count", 32'(count),   32'd1);
        check("reprime_vec",   32'(out_vec), 32'h0AAAAA);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("reprime_drain", 32'(count), 32'd0);

        // Timestamp wrap on the 4-bit instance: events at ts 15 then 0
        for (int i = 0; i < 40 && (tb_ts % 16) != 15; i++) tick();
        w_in_valid = 1'b1;
        w_in_vec   = 21'h0000A5;
        tick();
        w_in_vec   = 21'h00005A;
        tick();
        w_in_valid = 1'b0;
        check("wrap_count",  32'(w_count),  32'd2);
        check("wrap_ts_hi",  32'(w_out_ts), 32'd15);
        check("wrap_vec_hi", 32'(w_out_vec), 32'h0000A5);
        w_out_ready = 1'b1;
        tick();
        w_out_ready = 1'b0;
        check("wrap_ts_lo",  32'(w_out_ts),  32'd0);
        check("wrap_vec_lo", 32'(w_out_vec), 32'h00005A);

        check("final_sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Absolute bound on run time.
    initial begin
        #200000;
        $display("FAIL timeout: got no summary, expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_b9_event_fifo
